// File: rtl/stream_packer_if.sv
// Valid/ready bus between a narrow word source, the packer, and a wide-word sink.
// The "master" side drives input words and output backpressure; the packer is the "slave".
interface stream_packer_if #(
    parameter int InWidth = 8,
    parameter int Ratio   = 4
);
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [InWidth-1:0]           in_data_i;
    logic                         flush_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [InWidth*Ratio-1:0]     out_data_o;
    logic [$clog2(Ratio+1)-1:0]   out_count_o;

    modport master (
        output in_valid_i, in_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_count_o
    );

    modport slave (
        input  in_valid_i, in_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_count_o
    );
endinterface

// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers Ratio input words (little-endian by arrival)
// into one wide word, with an explicit flush that emits a partially filled word.
module stream_packer #(
    parameter int InWidth = 8,
    parameter int Ratio   = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    stream_packer_if.slave bus
);
    localparam int OutW   = InWidth * Ratio;
    localparam int CntW   = $clog2(Ratio);
    localparam int CountW = $clog2(Ratio + 1);

    typedef enum logic {FILL, FULL} state_e;

    state_e              state_p0;
    logic [CntW-1:0]     cnt_p0;
    logic [OutW-1:0]     acc_p0;
    logic [OutW-1:0]     out_data_p1;
    logic [CountW-1:0]   out_count_p1;
    logic                vld_p1;

    logic [OutW-1:0]     acc_nxt;
    logic [OutW-1:0]     lane0_word;
    logic                in_fire;
    logic                out_fire;
    logic                emit;

    // Only combinational path: FULL hands input acceptance straight to the sink's ready.
    assign bus.in_ready_o  = (state_p0 == FILL) | bus.out_ready_i;
    assign bus.out_valid_o = vld_p1;
    assign bus.out_data_o  = out_data_p1;
    assign bus.out_count_o = out_count_p1;

    assign in_fire    = bus.in_valid_i & bus.in_ready_o;
    assign out_fire   = vld_p1 & bus.out_ready_i;
    assign lane0_word = {{(OutW-InWidth){1'b0}}, bus.in_data_i};

    always_comb begin
        acc_nxt = acc_p0;
        if (in_fire) begin
            acc_nxt[cnt_p0*InWidth +: InWidth] = bus.in_data_i;
        end
    end

    // A word completes on the last lane, or on a flush that has something to send.
    assign emit = (in_fire && (cnt_p0 == CntW'(Ratio - 1)))
               || (bus.flush_i && ((cnt_p0 != '0) || in_fire));

    // Stage p0 -> p1: accumulator lanes feed the registered output word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_p0     <= FILL;
            cnt_p0       <= '0;
            acc_p0       <= '0;
            out_data_p1  <= '0;
            out_count_p1 <= '0;
            vld_p1       <= 1'b0;
        end else begin
            case (state_p0)
                FILL: begin
                    if (emit) begin
                        state_p0     <= FULL;
                        vld_p1       <= 1'b1;
                        out_data_p1  <= acc_nxt;
                        out_count_p1 <= CountW'(cnt_p0) + CountW'(in_fire);
                        cnt_p0       <= '0;
                        acc_p0       <= '0;
                    end else if (in_fire) begin
                        acc_p0 <= acc_nxt;
                        cnt_p0 <= cnt_p0 + CntW'(1);
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_p0     <= FILL;
                        vld_p1       <= 1'b0;
                        out_data_p1  <= '0;
                        out_count_p1 <= '0;
                        if (in_fire) begin
                            acc_p0 <= lane0_word;
                            cnt_p0 <= CntW'(1);
                        end else begin
                            acc_p0 <= '0;
                            cnt_p0 <= '0;
                        end
                    end
                end
                default: state_p0 <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_packer.sv
// Directed-vector bench for stream_packer (InWidth=8, Ratio=4) with a queue-based
// scoreboard checked by an independent output monitor.
module tb_stream_packer;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    stream_packer_if #(.InWidth(8), .Ratio(4)) bus ();

    stream_packer #(.InWidth(8), .Ratio(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  count;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge clk_i) begin
        if (!reset_i && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %h count %0d, expected no output",
                         bus.out_data_o, bus.out_count_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", bus.out_data_o, e.data);
                chk("out_count", 32'(bus.out_count_o), 32'(e.count));
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic f);
        bus.in_valid_i = v;
        bus.in_data_i  = d;
        bus.flush_i    = f;
        @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
        exp_t e;
        e.data  = d;
        e.count = c;
        q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
        chk({tag, "_data"}, bus.out_data_o, 32'd0);
        chk({tag, "_count"}, 32'(bus.out_count_o), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 8'h00;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        reset_i         = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        chk_reset_outputs("reset");
        reset_i = 1'b0;

        // Full word, one-cycle latency after the last lane
        expect_word(32'h44332211, 3'd4);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("t1_not_yet_valid", 32'(bus.out_valid_o), 32'd0);
        step(1'b1, 8'h44, 1'b0);
        chk("t1_valid", 32'(bus.out_valid_o), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        // Partial flush, then a flush with nothing pending
        expect_word(32'h0000BBAA, 3'd2);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("t2_valid", 32'(bus.out_valid_o), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("t2_empty_flush_ignored", 32'(bus.out_valid_o), 32'd0);
        step(1'b0, 8'h00, 1'b0);

        // Flush together with an input word at cnt=0
        expect_word(32'h00000077, 3'd1);
        step(1'b1, 8'h77, 1'b1);
        chk("t3_valid", 32'(bus.out_valid_o), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        // Backpressure: word held, input refused
        bus.out_ready_i = 1'b0;
        expect_word(32'h04030201, 3'd4);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'h99;
            #1;
            chk("t4_in_ready_low", 32'(bus.in_ready_o), 32'd0);
            chk("t4_data_stable", bus.out_data_o, 32'h04030201);
            chk("t4_valid_held", 32'(bus.out_valid_o), 32'd1);
            step(1'b1, 8'h99, 1'b0);
        end
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'h55;
        #1;
        chk("t4_in_ready_release", 32'(bus.in_ready_o), 32'd1);
        expect_word(32'h88776655, 3'd4);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h88, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Final lane and flush in the same cycle count as a full word
        expect_word(32'hC4C3C2C1, 3'd4);
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'hC4, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Streaming with no bubbles
        expect_word(32'h03020100, 3'd4);
        expect_word(32'h07060504, 3'd4);
        expect_word(32'h0B0A0908, 3'd4);
        expect_word(32'h0F0E0D0C, 3'd4);
        for (int i = 0; i < 16; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'(i);
            #1;
            chk("t5_in_ready", 32'(bus.in_ready_o), 32'd1);
            step(1'b1, 8'(i), 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);

        // Reset mid-fill discards the partial word
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        reset_i = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk_reset_outputs("t6_reset");
        reset_i = 1'b0;
        expect_word(32'hA3A2A1A0, 3'd4);
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_packer.md
# stream_packer

Narrow-to-wide valid/ready stream packer that consumes words from a FIFO read port, or any valid/ready source, and emits wide words. It collects `Ratio` input words of `InWidth` bits into one `InWidth*Ratio`-bit output word. An explicit flush emits a partially filled word. It sits downstream of the byte FIFO and feeds wide-bus consumers such as memory writers and DMA beats.

## Interface
Parameters:
- `InWidth`, default 8: input word width in bits.
- `Ratio`, default 4: input words per output word; must be ≥ 2.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  input word available.
- `in_ready_o`  out  1  packer accepts input this cycle.
- `in_data_i`  in  InWidth  input word; valid in the same cycle as `in_valid_i`.
- `flush_i`  in  1  request to emit the current partial word.
- `out_valid_o`  out  1  output word available.
- `out_ready_i`  in  1  downstream accepts output.
- `out_data_o`  out  InWidth*Ratio  packed word.
- `out_count_o`  out  $clog2(Ratio+1)  number of valid lanes in `out_data_o` (1..Ratio).

## Operation
Handshakes:
- Input transfer when `in_valid_i & in_ready_o`.
- Output transfer when `out_valid_o & out_ready_i`.

Packing order is little-endian by arrival: the k-th accepted word of a group goes to bits `[k*InWidth +: InWidth]`.

Internal state is a lane counter `cnt` (0..Ratio-1) plus a two-state FSM:
- **FILL**:
  - `out_valid_o`=0, `in_ready_o`=1.
  - Each accepted word writes lane `cnt`, then `cnt`+1.
  - When the accepted word fills lane Ratio-1, go to FULL with `out_count_o`=Ratio and `cnt`=0.
  - Flush: if `flush_i`=1 and (`cnt`>0 or an input is accepted this cycle), go to FULL. `out_count_o` = `cnt` + (1 if an input is accepted this cycle). A word accepted in the flush cycle is included in the flushed word. `cnt` is then cleared.
  - If `flush_i`=1 with `cnt`=0 and no input accepted, the flush is ignored and no output is produced.
- **FULL**:
  - `out_valid_o`=1.
  - `out_data_o` and `out_count_o` are held stable until the output transfer.
  - `in_ready_o` = `out_ready_i` (combinational pass-through; the only comb path in the block).
  - `flush_i` is ignored.
  - On output transfer: go to FILL. If an input is accepted in the same cycle, it is written to lane 0 of the next word and `cnt`=1; otherwise `cnt`=0.

Other rules:
- Lanes at or above `out_count_o` in an emitted word are zero. The accumulator is cleared at every output transfer, with the concurrently accepted word's lane 0 applied on top.
- `out_valid_o` never deasserts without a transfer.

Reset:
- State FILL, `cnt`=0, accumulator 0.
- Outputs: `out_valid_o`=0, `out_data_o`=0, `out_count_o`=0, `in_ready_o`=1.
- Reset mid-fill or mid-FULL discards all partial or pending data; no output is produced for it.

## Timing
- Latency: an output word is valid in the cycle after the input transfer that completes it, or after the flush cycle.
- Throughput: with `out_ready_i` held at 1, input is accepted every cycle with no bubbles, giving one output per Ratio input cycles.
- Backpressure: while in FULL with `out_ready_i`=0, `in_ready_o`=0 and there is no input transfer.
- Simultaneous output transfer and input transfer in FULL: both complete in that cycle, and the next group starts with `cnt`=1.
- Simultaneous final-lane input and `flush_i` in FILL: treated as a normal full word, `out_count_o`=Ratio.

## Test plan
All scenarios use `InWidth`=8, `Ratio`=4.
1. Full word: feed 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready_i`=1. Required: the cycle after 0x44 is accepted, `out_valid_o`=1, `out_data_o`=0x44332211, `out_count_o`=4.
2. Partial flush: feed 0xAA, 0xBB, then pulse `flush_i` with `in_valid_i`=0. Required: next cycle `out_data_o`=0x0000BBAA, `out_count_o`=2. A second flush pulse with `cnt`=0 produces no output.
3. Flush with concurrent input: with `cnt`=0, assert `flush_i` and `in_valid_i` with data 0x77. Required: `out_data_o`=0x00000077, `out_count_o`=1.
4. Backpressure: complete word 0x04030201 while `out_ready_i`=0 for 5 cycles. Required: `in_ready_o`=0 and `out_data_o` stable throughout. Then raise `out_ready_i` with `in_valid_i`=1, data 0x55. Required: both transfers occur in that cycle, and the next emitted word has lane 0 = 0x55.
5. Streaming: 16 consecutive input words 0x00..0x0F with `out_ready_i`=1. Required: `in_ready_o` never low; outputs are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
6. Reset mid-operation: assert `reset_i` for one cycle after 3 words are accepted. Required: all outputs return to reset values. The next 4 words (0xA0..0xA3) produce exactly one word 0xA3A2A1A0.
